// File: rtl/triumph_id_stage_pipe.sv
// RV32I decode stage: field/immediate decode, operand forwarding from EX/WB,
// load-use hazard stall, and a registered valid/ready output bundle.
module triumph_id_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 16,
    localparam int REG_W = $clog2(NREG)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [31:0]      instr_data_i,
    input  logic [XLEN-1:0]  instr_pc_i,
    input  logic             flush_i,
    output logic [REG_W-1:0] rs1_addr_o,
    input  logic [XLEN-1:0]  rs1_data_i,
    output logic [REG_W-1:0] rs2_addr_o,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic             ex_rd_we_i,
    input  logic [REG_W-1:0] ex_rd_addr_i,
    input  logic [XLEN-1:0]  ex_rd_data_i,
    input  logic             ex_is_load_i,
    input  logic             wb_rd_we_i,
    input  logic [REG_W-1:0] wb_rd_addr_i,
    input  logic [XLEN-1:0]  wb_rd_data_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [XLEN-1:0]  op1_o,
    output logic [XLEN-1:0]  op2_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  store_data_o,
    output logic [REG_W-1:0] rd_addr_o,
    output logic             rd_we_o,
    output logic [6:0]       opcode_o,
    output logic [2:0]       funct3_o,
    output logic [6:0]       funct7_o,
    output logic [2:0]       instr_type_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [2:0] {
        T_R   = 3'd0,
        T_I   = 3'd1,
        T_S   = 3'd2,
        T_B   = 3'd3,
        T_U   = 3'd4,
        T_J   = 3'd5,
        T_ILL = 3'd7
    } itype_e;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic [6:0]       opcode;
    logic [REG_W-1:0] rs1, rs2, rd;
    itype_e           itype;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]  imm_x, rs1_fwd, rs2_fwd, op1_d, op2_d;
    logic             rs1_used, rs2_used, hazard, fire_in, rd_we_d;

    assign opcode     = instr_data_i[6:0];
    assign rd         = REG_W'(instr_data_i[11:7]);
    assign rs1        = REG_W'(instr_data_i[19:15]);
    assign rs2        = REG_W'(instr_data_i[24:20]);
    assign rs1_addr_o = rs1;
    assign rs2_addr_o = rs2;

    // NOTE: every variable driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        itype = T_ILL;
        case (opcode)
            7'b0110011:                         itype = T_R;
            7'b0010011, 7'b0000011, 7'b1100111: itype = T_I;
            7'b0100011:                         itype = T_S;
            7'b1100011:                         itype = T_B;
            OP_LUI, OP_AUIPC:                   itype = T_U;
            OP_JAL:                             itype = T_J;
            default:                            itype = T_ILL;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (itype)
            T_I: imm32 = {{20{instr_data_i[31]}}, instr_data_i[31:20]};
            T_S: imm32 = {{20{instr_data_i[31]}}, instr_data_i[31:25], instr_data_i[11:7]};
            T_B: imm32 = {{19{instr_data_i[31]}}, instr_data_i[31], instr_data_i[7],
                          instr_data_i[30:25], instr_data_i[11:8], 1'b0};
            T_U: imm32 = {instr_data_i[31:12], 12'b0};
            T_J: imm32 = {{11{instr_data_i[31]}}, instr_data_i[31], instr_data_i[19:12],
                          instr_data_i[20], instr_data_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast sign-extends the 32-bit immediate to the datapath width.
    assign imm_x = XLEN'(imm32);

    function automatic logic [XLEN-1:0] fwd(input logic [REG_W-1:0] a,
                                            input logic [XLEN-1:0]  rf);
        if (a == '0)
            return '0;
        else if (ex_rd_we_i && !ex_is_load_i && ex_rd_addr_i == a)
            return ex_rd_data_i;
        else if (wb_rd_we_i && wb_rd_addr_i == a)
            return wb_rd_data_i;
        else
            return rf;
    endfunction

    assign rs1_fwd = fwd(rs1, rs1_data_i);
    assign rs2_fwd = fwd(rs2, rs2_data_i);

    assign rs1_used = (itype == T_R) || (itype == T_I) || (itype == T_S) || (itype == T_B);
    assign rs2_used = (itype == T_R) || (itype == T_S) || (itype == T_B);

    assign hazard = instr_valid_i && ex_is_load_i && ex_rd_we_i && (ex_rd_addr_i != '0) &&
                    ((rs1_used && rs1 == ex_rd_addr_i) || (rs2_used && rs2 == ex_rd_addr_i));

    assign instr_ready_o = (!id_valid_o || id_ready_i) && !hazard;
    assign fire_in       = instr_valid_i && instr_ready_o && !flush_i;

    always_comb begin
        op1_d = '0;
        op2_d = imm_x;
        case (itype)
            T_R, T_B: begin op1_d = rs1_fwd; op2_d = rs2_fwd; end
            T_I, T_S: op1_d = rs1_fwd;
            T_J:      op1_d = instr_pc_i;
            T_U:      op1_d = (opcode == OP_AUIPC) ? instr_pc_i : '0;
            default:  op1_d = '0;
        endcase
    end

    assign rd_we_d = (rd != '0) &&
                     ((itype == T_R) || (itype == T_I) || (itype == T_U) || (itype == T_J));

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so a
    // reset mid-stall clears the bundle without waiting for an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_valid_o   <= 1'b0;
            op1_o        <= '0;
            op2_o        <= '0;
            imm_o        <= '0;
            pc_o         <= '0;
            store_data_o <= '0;
            rd_addr_o    <= '0;
            rd_we_o      <= 1'b0;
            opcode_o     <= '0;
            funct3_o     <= '0;
            funct7_o     <= '0;
            instr_type_o <= '0;
            stall_cnt_o  <= '0;
        end else begin
            id_valid_o <= !flush_i && (fire_in || (id_valid_o && !id_ready_i));
            if (fire_in) begin
                op1_o        <= op1_d;
                op2_o        <= op2_d;
                imm_o        <= imm_x;
                pc_o         <= instr_pc_i;
                store_data_o <= rs2_fwd;
                rd_addr_o    <= rd;
                rd_we_o      <= rd_we_d;
                opcode_o     <= opcode;
                funct3_o     <= instr_data_i[14:12];
                funct7_o     <= instr_data_i[31:25];
                instr_type_o <= itype;
            end
            // A flush outranks the hazard, so a flushed stall cycle is not counted.
            if (hazard && !flush_i && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_triumph_id_stage_pipe.sv
// Directed bench for triumph_id_stage_pipe: decode, forwarding, load-use stall,
// backpressure, flush, counter saturation and asynchronous reset.
module tb_triumph_id_stage_pipe;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int CNT_W = 4;
    localparam int REG_W = $clog2(NREG);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             instr_valid_i, instr_ready_o, flush_i;
    logic [31:0]      instr_data_i;
    logic [XLEN-1:0]  instr_pc_i;
    logic [REG_W-1:0] rs1_addr_o, rs2_addr_o;
    logic [XLEN-1:0]  rs1_data_i, rs2_data_i;
    logic             ex_rd_we_i, ex_is_load_i, wb_rd_we_i;
    logic [REG_W-1:0] ex_rd_addr_i, wb_rd_addr_i;
    logic [XLEN-1:0]  ex_rd_data_i, wb_rd_data_i;
    logic             id_valid_o, id_ready_i, rd_we_o;
    logic [XLEN-1:0]  op1_o, op2_o, imm_o, pc_o, store_data_o;
    logic [REG_W-1:0] rd_addr_o;
    logic [6:0]       opcode_o, funct7_o;
    logic [2:0]       funct3_o, instr_type_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk_i = ~clk_i;

    triumph_id_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_data_i(instr_data_i), .instr_pc_i(instr_pc_i), .flush_i(flush_i),
        .rs1_addr_o(rs1_addr_o), .rs1_data_i(rs1_data_i),
        .rs2_addr_o(rs2_addr_o), .rs2_data_i(rs2_data_i),
        .ex_rd_we_i(ex_rd_we_i), .ex_rd_addr_i(ex_rd_addr_i),
        .ex_rd_data_i(ex_rd_data_i), .ex_is_load_i(ex_is_load_i),
        .wb_rd_we_i(wb_rd_we_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o), .pc_o(pc_o),
        .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o),
        .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
        .instr_type_o(instr_type_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        instr_valid_i = 1'b1;
        instr_data_i  = instr;
        instr_pc_i    = pc;
    endtask

    initial begin
        rst_i = 1'b1; instr_valid_i = 1'b0; instr_data_i = '0; instr_pc_i = '0; flush_i = 1'b0;
        rs1_data_i = '0; rs2_data_i = '0; id_ready_i = 1'b1;
        ex_rd_we_i = 1'b0; ex_rd_addr_i = '0; ex_rd_data_i = '0; ex_is_load_i = 1'b0;
        wb_rd_we_i = 1'b0; wb_rd_addr_i = '0; wb_rd_data_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        check("rst_valid", id_valid_o, 0);
        check("rst_stall", stall_cnt_o, 0);
        check("rst_op1", op1_o, 0);
        check("rst_imm", imm_o, 0);
        check("rst_ready", instr_ready_o, 1);

        // ADDI x5,x0,-1 ; rs1 is x0 so regfile data must be ignored
        offer(32'hFFF00293, 32'h40);
        rs1_data_i = 32'h1234;
        #1;
        check("addi_ready", instr_ready_o, 1);
        check("addi_rs1a", rs1_addr_o, 0);
        tick();
        check("addi_valid", id_valid_o, 1);
        check("addi_imm", imm_o, 32'hFFFFFFFF);
        check("addi_op2", op2_o, 32'hFFFFFFFF);
        check("addi_op1", op1_o, 0);
        check("addi_rd", rd_addr_o, 5);
        check("addi_we", rd_we_o, 1);
        check("addi_type", instr_type_o, 1);
        check("addi_pc", pc_o, 32'h40);

        // ADD x3,x1,x2 with EX forwarding x1 and WB forwarding x2
        offer(32'h002081B3, 32'h44);
        rs1_data_i = '0; rs2_data_i = '0;
        ex_rd_we_i = 1; ex_rd_addr_i = 1; ex_rd_data_i = 32'h10;
        wb_rd_we_i = 1; wb_rd_addr_i = 2; wb_rd_data_i = 32'h20;
        #1;
        check("add_rs1a", rs1_addr_o, 1);
        check("add_rs2a", rs2_addr_o, 2);
        tick();
        check("add_op1", op1_o, 32'h10);
        check("add_op2", op2_o, 32'h20);
        check("add_type", instr_type_o, 0);
        check("add_rd", rd_addr_o, 3);

        // EX beats WB on x1; x2 falls back to the regfile
        wb_rd_addr_i = 1; wb_rd_data_i = 32'h99; rs2_data_i = 32'h55;
        tick();
        check("prio_op1", op1_o, 32'h10);
        check("prio_op2", op2_o, 32'h55);

        // Load-use: LW x4 in EX, ADD x6,x4,x4 offered
        wb_rd_we_i = 0; rs2_data_i = '0;
        ex_rd_we_i = 1; ex_rd_addr_i = 4; ex_rd_data_i = 32'hDEAD; ex_is_load_i = 1;
        offer(32'h00420333, 32'h48);
        #1;
        check("lu_ready", instr_ready_o, 0);
        tick();
        check("lu_bubble", id_valid_o, 0);
        check("lu_stall", stall_cnt_o, 1);
        ex_is_load_i = 0; ex_rd_we_i = 0;
        wb_rd_we_i = 1; wb_rd_addr_i = 4; wb_rd_data_i = 32'h77;
        #1;
        check("lu_ready2", instr_ready_o, 1);
        tick();
        check("lu_valid", id_valid_o, 1);
        check("lu_op1", op1_o, 32'h77);
        check("lu_op2", op2_o, 32'h77);
        check("lu_rd", rd_addr_o, 6);
        check("lu_stall2", stall_cnt_o, 1);

        // Backpressure: hold for 3 cycles with JAL offered
        wb_rd_we_i = 0;
        id_ready_i = 0;
        offer(32'h001000EF, 32'h100);
        #1;
        check("bp_ready", instr_ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", id_valid_o, 1);
            check("bp_rd", rd_addr_o, 6);
            check("bp_op1", op1_o, 32'h77);
        end
        id_ready_i = 1;
        #1;
        check("bp_ready2", instr_ready_o, 1);
        tick();
        check("jal_type", instr_type_o, 5);
        check("jal_imm", imm_o, 32'h800);
        check("jal_op1", op1_o, 32'h100);
        check("jal_op2", op2_o, 32'h800);
        check("jal_rd", rd_addr_o, 1);
        check("jal_we", rd_we_o, 1);

        // LUI x7,0x12345 ; op1 forced to 0
        offer(32'h123453B7, 32'h104);
        rs1_data_i = 32'hFFFF;
        tick();
        check("lui_op1", op1_o, 0);
        check("lui_op2", op2_o, 32'h12345000);
        check("lui_type", instr_type_o, 4);
        check("lui_rd", rd_addr_o, 7);

        // AUIPC x10,1 at pc 0x200
        offer(32'h00001517, 32'h200);
        tick();
        check("auipc_op1", op1_o, 32'h200);
        check("auipc_op2", op2_o, 32'h1000);

        // SW x2,8(x1)
        offer(32'h0020A423, 32'h204);
        rs1_data_i = 32'h1000; rs2_data_i = 32'hAB;
        tick();
        check("sw_type", instr_type_o, 2);
        check("sw_imm", imm_o, 8);
        check("sw_op1", op1_o, 32'h1000);
        check("sw_op2", op2_o, 8);
        check("sw_sdata", store_data_o, 32'hAB);
        check("sw_we", rd_we_o, 0);
        check("sw_f3", funct3_o, 2);

        // BNE x1,x2,-4
        offer(32'hFE209EE3, 32'h208);
        tick();
        check("bne_type", instr_type_o, 3);
        check("bne_imm", imm_o, 32'hFFFFFFFC);
        check("bne_op2", op2_o, 32'hAB);
        check("bne_we", rd_we_o, 0);

        // NOP (addi x0): rd==0 disables write
        offer(32'h00000013, 32'h20C);
        tick();
        check("nop_type", instr_type_o, 1);
        check("nop_we", rd_we_o, 0);

        // Illegal opcode still issues
        offer(32'h00000000, 32'h210);
        tick();
        check("ill_valid", id_valid_o, 1);
        check("ill_type", instr_type_o, 7);
        check("ill_we", rd_we_o, 0);
        check("ill_imm", imm_o, 0);

        // Flush kills held bundle and offered instruction
        id_ready_i = 0; flush_i = 1;
        offer(32'hFFF00293, 32'h300);
        tick();
        check("fl_valid", id_valid_o, 0);

        // Flush together with hazard: counter must not move
        id_ready_i = 1;
        ex_rd_we_i = 1; ex_rd_addr_i = 4; ex_is_load_i = 1;
        offer(32'h00420333, 32'h304);
        tick();
        check("flh_stall", stall_cnt_o, 1);
        check("flh_valid", id_valid_o, 0);

        // Load a bundle, then stall under backpressure until the counter saturates
        flush_i = 0; ex_is_load_i = 0; ex_rd_we_i = 0;
        offer(32'hFFF00293, 32'h308);
        tick();
        check("sat_pre_valid", id_valid_o, 1);
        id_ready_i = 0;
        ex_rd_we_i = 1; ex_rd_addr_i = 4; ex_is_load_i = 1;
        offer(32'h00420333, 32'h30C);
        tick();
        check("sat_first", stall_cnt_o, 2);
        for (int i = 0; i < 15; i++) tick();
        check("sat_cnt", stall_cnt_o, 15);
        check("sat_hold", id_valid_o, 1);
        check("sat_op2", op2_o, 32'hFFFFFFFF);

        // Asynchronous reset mid-stall, sampled before any clock edge
        #2 rst_i = 1;
        #1;
        check("arst_valid", id_valid_o, 0);
        check("arst_stall", stall_cnt_o, 0);
        check("arst_op2", op2_o, 0);
        check("arst_pc", pc_o, 0);
        tick();
        rst_i = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
